// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap entry/return controller with exception priority, interrupt latching and double-fault halt
module trap_ctrl #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] MAX_ROM_ADDR = 16'h007C,
    parameter logic [ADDR_W-1:0] MAX_RAM_ADDR = 16'h007C,
    parameter int                N_IRQ        = 4,
    parameter logic [ADDR_W-1:0] TRAP_VEC     = 16'h0040
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [N_IRQ-1:0]  irq,
    input  logic [N_IRQ-1:0]  irq_mask,
    input  logic              mie,
    input  logic              mret_in,
    output logic              trap,
    output logic              ret,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       mcause,
    output logic [31:0]       mepc,
    output logic [31:0]       mtval,
    output logic [N_IRQ-1:0]  pending,
    output logic              in_handler,
    output logic              halted,
    output logic [15:0]       trap_count
);

    localparam int PAD_W = 32 - ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTER,
        S_HANDLER,
        S_HALT
    } state_t;

    state_t state;
    state_t state_next;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             opc_legal;
    logic             pc_bad;
    logic             addr_bad;
    logic             is_load;
    logic             is_store;

    logic             exc_any;
    logic [4:0]       exc_code;
    logic [31:0]      exc_tval;

    logic [N_IRQ-1:0] irq_act;
    logic             irq_any;
    logic [3:0]       irq_idx;
    logic [N_IRQ-1:0] irq_clr;

    logic             take_exc;
    logic             take_irq;
    logic             take_trap;
    logic             halt_exc;
    logic             do_ret;
    logic [31:0]      cause_next;
    logic [31:0]      tval_next;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_load  = (opcode == 7'd3);
    assign is_store = (opcode == 7'd35);
    assign pc_bad   = (pc > MAX_ROM_ADDR) || (pc[1:0] != 2'b00);
    // Out-of-range applies to every access width; misalignment only matters for word accesses.
    assign addr_bad = (mem_addr > MAX_RAM_ADDR) ||
                      ((funct3 == 3'b010) && (mem_addr[1:0] != 2'b00));

    // Opcode whitelist: load, op-imm, store, op, branch, jal, system.
    always_comb begin
        opc_legal = 1'b0;
        case (opcode)
            7'd3, 7'd19, 7'd35, 7'd51, 7'd99, 7'd111, 7'd115: opc_legal = 1'b1;
            default: opc_legal = 1'b0;
        endcase
    end

    // Exception priority encoder: fetch fault, illegal instr, load fault, store fault.
    always_comb begin
        exc_any  = 1'b0;
        exc_code = 5'd0;
        exc_tval = 32'd0;
        if (pc_bad) begin
            exc_any  = 1'b1;
            exc_code = 5'd0;
            exc_tval = {{PAD_W{1'b0}}, pc};
        end else if (!opc_legal) begin
            exc_any  = 1'b1;
            exc_code = 5'd2;
            exc_tval = instr;
        end else if (is_load && addr_bad) begin
            exc_any  = 1'b1;
            exc_code = 5'd4;
            exc_tval = {{PAD_W{1'b0}}, mem_addr};
        end else if (is_store && addr_bad) begin
            exc_any  = 1'b1;
            exc_code = 5'd6;
            exc_tval = {{PAD_W{1'b0}}, mem_addr};
        end
    end

    assign irq_act = pending & irq_mask;
    assign irq_any = |irq_act;

    // Lowest enabled pending line wins; scanning downward lets the smallest index overwrite last.
    always_comb begin
        irq_idx = 4'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq_act[i]) begin
                irq_idx = 4'(i);
            end
        end
    end

    assign take_exc  = (state == S_IDLE) && valid_in && exc_any;
    assign take_irq  = (state == S_IDLE) && valid_in && mie && !exc_any && irq_any;
    assign take_trap = take_exc || take_irq;
    assign halt_exc  = (state == S_HANDLER) && valid_in && exc_any;
    // A fault inside the handler outranks a simultaneous mret: the core is locked, not resumed.
    assign do_ret    = (state == S_HANDLER) && mret_in && !halt_exc;

    // Interrupt code is 16+i, i.e. bit 4 set above the 4-bit line index.
    assign cause_next = take_exc ? {27'd0, exc_code} : {1'b1, 26'd0, 1'b1, irq_idx};
    assign tval_next  = take_exc ? exc_tval : 32'd0;

    // Only the line actually being serviced is consumed from pending.
    always_comb begin
        irq_clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (take_irq && (irq_idx == 4'(i))) begin
                irq_clr[i] = 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (take_trap) begin
                    state_next = S_ENTER;
                end
            end
            S_ENTER: begin
                state_next = S_HANDLER;
            end
            S_HANDLER: begin
                if (halt_exc) begin
                    state_next = S_HALT;
                end else if (do_ret) begin
                    state_next = S_IDLE;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Trap CSRs, pulses, redirect target, pending latch and entry counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap        <= 1'b0;
            ret         <= 1'b0;
            redirect_pc <= '0;
            mcause      <= 32'd0;
            mepc        <= 32'd0;
            mtval       <= 32'd0;
            pending     <= '0;
            trap_count  <= 16'd0;
        end else begin
            trap    <= take_trap;
            ret     <= do_ret;
            pending <= (pending | irq) & ~irq_clr;
            if (take_trap) begin
                redirect_pc <= TRAP_VEC;
                mcause      <= cause_next;
                mepc        <= {{PAD_W{1'b0}}, pc};
                mtval       <= tval_next;
                if (trap_count != 16'hFFFF) begin
                    trap_count <= trap_count + 16'd1;
                end
            end else if (do_ret) begin
                redirect_pc <= mepc[ADDR_W-1:0];
            end
        end
    end

    assign in_handler = (state == S_HANDLER);
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - self-checking bench for trap_ctrl
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] instr;
    logic [15:0] pc;
    logic [15:0] mem_addr;
    logic [3:0]  irq;
    logic [3:0]  irq_mask;
    logic        mie;
    logic        mret_in;
    logic        trap;
    logic        ret;
    logic [15:0] redirect_pc;
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic [3:0]  pending;
    logic        in_handler;
    logic        halted;
    logic [15:0] trap_count;

    trap_ctrl dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .instr(instr), .pc(pc),
        .mem_addr(mem_addr), .irq(irq), .irq_mask(irq_mask), .mie(mie),
        .mret_in(mret_in), .trap(trap), .ret(ret), .redirect_pc(redirect_pc),
        .mcause(mcause), .mepc(mepc), .mtval(mtval), .pending(pending),
        .in_handler(in_handler), .halted(halted), .trap_count(trap_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] instr;
        logic [15:0] pc;
        logic [15:0] addr;
        logic [3:0]  irq_pre;
        logic [3:0]  mask;
        logic        mie;
        logic        exp_trap;
        logic [31:0] exp_cause;
        logic [31:0] exp_tval;
        logic [3:0]  exp_pend;
    } vec_t;

    typedef struct {
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        trap_q[$];
    logic [15:0] ret_q[$];
    vec_t        vecs[23];

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0;
        instr    = 32'h0000_0013;
        pc       = 16'h0000;
        mem_addr = 16'h0000;
        irq      = 4'b0000;
        irq_mask = 4'b0000;
        mie      = 1'b0;
        mret_in  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic push_trap(input logic [31:0] cause, input logic [15:0] epc, input logic [31:0] tval);
        exp_t e;
        e.cause = cause;
        e.epc   = {16'h0000, epc};
        e.tval  = tval;
        trap_q.push_back(e);
    endtask

    // Pops the oldest expected trap entry once the DUT shows its trap pulse.
    task automatic pop_trap(input string nm);
        exp_t e;
        if (trap !== 1'b1 || trap_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_trap: trap=%b queued=%0d want trap=1 with entry queued", nm, trap, trap_q.size());
            if (trap_q.size() != 0) trap_q.delete(0);
        end else begin
            e = trap_q.pop_front();
            chk({nm, "_mcause"}, mcause, e.cause);
            chk({nm, "_mepc"}, mepc, e.epc);
            chk({nm, "_mtval"}, mtval, e.tval);
            chk({nm, "_redirect"}, {16'h0000, redirect_pc}, 32'h0000_0040);
        end
    endtask

    task automatic pop_ret(input string nm);
        logic [15:0] r;
        if (ret !== 1'b1 || ret_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_ret: ret=%b queued=%0d want ret=1 with entry queued", nm, ret, ret_q.size());
            if (ret_q.size() != 0) ret_q.delete(0);
        end else begin
            r = ret_q.pop_front();
            chk({nm, "_ret_redirect"}, {16'h0000, redirect_pc}, {16'h0000, r});
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_trap"}, {31'd0, trap}, 32'd0);
        chk({nm, "_ret"}, {31'd0, ret}, 32'd0);
        chk({nm, "_redirect"}, {16'd0, redirect_pc}, 32'd0);
        chk({nm, "_mcause"}, mcause, 32'd0);
        chk({nm, "_mepc"}, mepc, 32'd0);
        chk({nm, "_mtval"}, mtval, 32'd0);
        chk({nm, "_pending"}, {28'd0, pending}, 32'd0);
        chk({nm, "_in_handler"}, {31'd0, in_handler}, 32'd0);
        chk({nm, "_halted"}, {31'd0, halted}, 32'd0);
        chk({nm, "_count"}, {16'd0, trap_count}, 32'd0);
    endtask

    initial begin
        //             name                 v  instr         pc      addr    pre      mask     mie  trap cause         tval          pend
        vecs[0]  = '{"addi_ok",            1, 32'h00000013, 16'h10, 16'h00, 4'b0000, 4'b0000, 0, 0, 32'h0,        32'h0,        4'b0000};
        vecs[1]  = '{"illegal_op07",       1, 32'h00000007, 16'h10, 16'h00, 4'b0000, 4'b0000, 0, 1, 32'h2,        32'h00000007, 4'b0000};
        vecs[2]  = '{"pc_over",            1, 32'h00000013, 16'h80, 16'h00, 4'b0000, 4'b0000, 0, 1, 32'h0,        32'h80,       4'b0000};
        vecs[3]  = '{"pc_misalign",        1, 32'h00000013, 16'h12, 16'h00, 4'b0000, 4'b0000, 0, 1, 32'h0,        32'h12,       4'b0000};
        vecs[4]  = '{"pc_max",             1, 32'h00000013, 16'h7C, 16'h00, 4'b0000, 4'b0000, 0, 0, 32'h0,        32'h0,        4'b0000};
        vecs[5]  = '{"lw_over",            1, 32'h00002003, 16'h10, 16'h80, 4'b0000, 4'b0000, 0, 1, 32'h4,        32'h80,       4'b0000};
        vecs[6]  = '{"lw_max",             1, 32'h00002003, 16'h10, 16'h7C, 4'b0000, 4'b0000, 0, 0, 32'h0,        32'h0,        4'b0000};
        vecs[7]  = '{"lw_misalign",        1, 32'h00002003, 16'h10, 16'h02, 4'b0000, 4'b0000, 0, 1, 32'h4,        32'h02,       4'b0000};
        vecs[8]  = '{"lb_unaligned_ok",    1, 32'h00000003, 16'h10, 16'h01, 4'b0000, 4'b0000, 0, 0, 32'h0,        32'h0,        4'b0000};
        vecs[9]  = '{"lb_over",            1, 32'h00000003, 16'h10, 16'h7D, 4'b0000, 4'b0000, 0, 1, 32'h4,        32'h7D,       4'b0000};
        vecs[10] = '{"sw_over",            1, 32'h00002023, 16'h10, 16'h80, 4'b0000, 4'b0000, 0, 1, 32'h6,        32'h80,       4'b0000};
        vecs[11] = '{"sw_misalign",        1, 32'h00002023, 16'h10, 16'h06, 4'b0000, 4'b0000, 0, 1, 32'h6,        32'h06,       4'b0000};
        vecs[12] = '{"sb_unaligned_ok",    1, 32'h00000023, 16'h10, 16'h03, 4'b0000, 4'b0000, 0, 0, 32'h0,        32'h0,        4'b0000};
        vecs[13] = '{"pc_beats_opcode",    1, 32'h00000000, 16'h81, 16'h00, 4'b0000, 4'b0000, 0, 1, 32'h0,        32'h81,       4'b0000};
        vecs[14] = '{"opcode_beats_addr",  1, 32'h00002007, 16'h10, 16'h80, 4'b0000, 4'b0000, 0, 1, 32'h2,        32'h00002007, 4'b0000};
        vecs[15] = '{"ecall_legal",        1, 32'h00000073, 16'h10, 16'h00, 4'b0000, 4'b0000, 0, 0, 32'h0,        32'h0,        4'b0000};
        vecs[16] = '{"lui_illegal",        1, 32'h00000037, 16'h10, 16'h00, 4'b0000, 4'b0000, 0, 1, 32'h2,        32'h00000037, 4'b0000};
        vecs[17] = '{"irq_lowest",         1, 32'h00000013, 16'h18, 16'h00, 4'b1010, 4'b1111, 1, 1, 32'h80000011, 32'h0,        4'b1000};
        vecs[18] = '{"irq_masked",         1, 32'h00000013, 16'h18, 16'h00, 4'b0100, 4'b1011, 1, 0, 32'h0,        32'h0,        4'b0100};
        vecs[19] = '{"irq_mie_off",        1, 32'h00000013, 16'h18, 16'h00, 4'b0001, 4'b1111, 0, 0, 32'h0,        32'h0,        4'b0001};
        vecs[20] = '{"irq_mask_pick",      1, 32'h00000013, 16'h1C, 16'h00, 4'b0110, 4'b0100, 1, 1, 32'h80000012, 32'h0,        4'b0010};
        vecs[21] = '{"exc_over_irq",       1, 32'h00000007, 16'h1C, 16'h00, 4'b0001, 4'b1111, 1, 1, 32'h2,        32'h00000007, 4'b0001};
        vecs[22] = '{"valid_low",          0, 32'h00000007, 16'h1C, 16'h00, 4'b0001, 4'b1111, 1, 0, 32'h0,        32'h0,        4'b0001};

        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        cyc();
        chk_all_zero("reset");
        rst = 1'b0;

        // Table: one detection cycle per vector, then a full handler round trip if it traps.
        for (int i = 0; i < 23; i++) begin
            do_reset();
            if (vecs[i].irq_pre != 4'b0000) begin
                irq = vecs[i].irq_pre;
                cyc();
                irq = 4'b0000;
            end
            valid_in = vecs[i].valid;
            instr    = vecs[i].instr;
            pc       = vecs[i].pc;
            mem_addr = vecs[i].addr;
            irq_mask = vecs[i].mask;
            mie      = vecs[i].mie;
            if (vecs[i].exp_trap) push_trap(vecs[i].exp_cause, vecs[i].pc, vecs[i].exp_tval);
            cyc();
            valid_in = 1'b0;
            if (vecs[i].exp_trap) pop_trap(vecs[i].name);
            else chk({vecs[i].name, "_no_trap"}, {31'd0, trap}, 32'd0);
            chk({vecs[i].name, "_pending"}, {28'd0, pending}, {28'd0, vecs[i].exp_pend});
            if (vecs[i].exp_trap) begin
                cyc();
                chk({vecs[i].name, "_in_handler"}, {31'd0, in_handler}, 32'd1);
                mret_in = 1'b1;
                ret_q.push_back(vecs[i].pc);
                cyc();
                mret_in = 1'b0;
                pop_ret(vecs[i].name);
                chk({vecs[i].name, "_left_handler"}, {31'd0, in_handler}, 32'd0);
            end
        end

        // Store fault beats a simultaneous interrupt; the interrupt is taken after mret.
        do_reset();
        valid_in = 1'b1; instr = 32'h0000_2023; pc = 16'h0010; mem_addr = 16'h0080;
        irq = 4'b0001; irq_mask = 4'b1111; mie = 1'b1;
        push_trap(32'h6, 16'h0010, 32'h80);
        cyc();
        irq = 4'b0000; instr = 32'h0000_0013; mem_addr = 16'h0000; pc = 16'h0014;
        pop_trap("sw_irq");
        chk("sw_irq_pending", {28'd0, pending}, 32'h1);
        cyc();
        chk("sw_irq_handler_no_trap", {31'd0, trap}, 32'd0);
        cyc();
        chk("sw_irq_handler_hold", {31'd0, in_handler}, 32'd1);
        chk("sw_irq_handler_pending", {28'd0, pending}, 32'h1);
        valid_in = 1'b0;
        mret_in = 1'b1;
        ret_q.push_back(16'h0010);
        cyc();
        mret_in = 1'b0;
        pop_ret("sw_irq");
        valid_in = 1'b1;
        push_trap(32'h8000_0010, 16'h0014, 32'h0);
        cyc();
        valid_in = 1'b0;
        pop_trap("irq0_after_mret");
        chk("irq0_cleared", {28'd0, pending}, 32'h0);

        // Fault inside the handler locks the controller until reset.
        do_reset();
        valid_in = 1'b1; instr = 32'h0000_0007; pc = 16'h0020;
        push_trap(32'h2, 16'h0020, 32'h7);
        cyc();
        valid_in = 1'b0;
        pop_trap("dbl_first");
        cyc();
        valid_in = 1'b1; instr = 32'h0000_0000; pc = 16'h0024;
        cyc();
        valid_in = 1'b0;
        chk("dbl_halted", {31'd0, halted}, 32'd1);
        chk("dbl_not_handler", {31'd0, in_handler}, 32'd0);
        chk("dbl_no_trap", {31'd0, trap}, 32'd0);
        chk("dbl_mcause_held", mcause, 32'h2);
        chk("dbl_mepc_held", mepc, 32'h20);
        chk("dbl_mtval_held", mtval, 32'h7);
        mret_in = 1'b1;
        cyc();
        chk("dbl_mret_ignored", {31'd0, ret}, 32'd0);
        valid_in = 1'b1; instr = 32'h0000_0007;
        cyc();
        chk("dbl_still_halted", {31'd0, halted}, 32'd1);
        chk("dbl_halt_no_trap", {31'd0, trap}, 32'd0);
        chk("dbl_count", {16'd0, trap_count}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle_inputs();
        chk_all_zero("dbl_reset");

        // Counter saturation: 65537 back-to-back trap/return rounds.
        do_reset();
        for (int k = 1; k <= 65537; k++) begin
            valid_in = 1'b1; instr = 32'h0000_0007; pc = 16'h0030;
            push_trap(32'h2, 16'h0030, 32'h7);
            cyc();
            valid_in = 1'b0;
            pop_trap("sat");
            if (k == 1) chk("sat_count_1", {16'd0, trap_count}, 32'd1);
            if (k == 65534) chk("sat_count_fffe", {16'd0, trap_count}, 32'hFFFE);
            if (k >= 65535) chk("sat_count_ffff", {16'd0, trap_count}, 32'hFFFF);
            cyc();
            mret_in = 1'b1;
            ret_q.push_back(16'h0030);
            cyc();
            mret_in = 1'b0;
            pop_ret("sat");
        end

        chk("trap_queue_drained", trap_q.size(), 32'd0);
        chk("ret_queue_drained", ret_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
